tmpl_match_ctrl: RTL and testbench
==================================

TMPL_MATCH_CTRL -- requirements
Module: tmpl_match_ctrl

Interface
REQ-001 SHALL have parameter N_TMPL, default 10, number of digit-template ROMs scanned per run.
REQ-002 SHALL have parameter ADDR_W, default 12, template ROM address width; 2^ADDR_W pixels per template.
REQ-003 SHALL have parameter SCORE_W, default ADDR_W+1, match-score width; holds 0..2^ADDR_W.
REQ-004 SHALL have port clk, input, 1, the single clock for all logic.
REQ-005 SHALL have port rst_n, input, 1, reset; asynchronous and active-low.
REQ-006 SHALL have port start, input, 1, run request; sampled only in IDLE.
REQ-007 SHALL have port abort, input, 1, cancels a run in progress.
REQ-008 SHALL have port busy, output, 1, high from the first SCAN cycle through DONE.
REQ-009 SHALL have port done, output, 1, one-cycle pulse when a run completes.
REQ-010 SHALL have port rom_ad, output, ADDR_W, the pixel address shared by the template ROMs and the image buffer.
REQ-011 SHALL have ports rom_ce and rom_oce, output, 1 each, ROM clock and output-register enables.
REQ-012 SHALL have port rom_reset, output, 1, ROM reset; driven constant 0.
REQ-013 SHALL have port tmpl_sel, output, $clog2(N_TMPL), selects which template ROM's dout is muxed onto rom_dout.
REQ-014 SHALL have port rom_dout, input, 1, selected template bit.
REQ-015 SHALL have port img_bit, input, 1, binarised image bit; read latency equals the ROM read latency.
REQ-016 SHALL have ports best_digit, output, $clog2(N_TMPL), and best_score, output, SCORE_W, the result of the last completed run.

Function
REQ-017 SHALL implement FSM states IDLE, SCAN, DRAIN, NEXT, DONE.
REQ-018 IDLE -> SCAN SHALL occur when start=1 and abort=0; on entry, rom_ad=0, tmpl_sel=0, and the run accumulators are cleared.
REQ-019 In SCAN, rom_ce=rom_oce=1 and rom_ad SHALL increment by 1 every cycle; after 2^ADDR_W-1 is issued, the FSM SHALL go to DRAIN.
REQ-020 A valid shift register of depth LAT SHALL track issued addresses; each valid returned bit pair SHALL add (rom_dout XNOR img_bit) to the per-template score.
REQ-021 DRAIN SHALL last exactly LAT cycles, rom_ce=1, rom_ad held; the FSM SHALL then go to NEXT.
REQ-022 NEXT (1 cycle) SHALL replace the run best when score > best (strict), or when tmpl_sel=0; a tie SHALL keep the lower digit.
REQ-023 NEXT SHALL go to DONE if tmpl_sel=N_TMPL-1; otherwise it SHALL increment tmpl_sel, clear the score and rom_ad, and go to SCAN.
REQ-024 DONE (1 cycle) SHALL assert done, copy the run best to best_digit/best_score, and return to IDLE.
REQ-025 Run duration SHALL be exactly N_TMPL*(2^ADDR_W+LAT+1)+1 cycles from the start-sampling edge to done high.
REQ-026 start while not in IDLE SHALL be ignored; start held high SHALL launch back-to-back runs, one IDLE cycle apart.
REQ-027 abort in any non-IDLE state SHALL force IDLE next cycle with no done; best_* SHALL keep the previous completed result; abort SHALL win over start.
REQ-028 Outside SCAN/DRAIN, rom_ce=rom_oce=0.
REQ-029 Score arithmetic SHALL be unsigned SCORE_W with no saturation; the maximum of 2^ADDR_W SHALL fit.

Reset
REQ-030 rst_n low SHALL asynchronously force IDLE, and set busy=0, done=0, rom_ce=rom_oce=0, rom_ad=0, tmpl_sel=0, best_digit=0, best_score=0.
REQ-031 Reset mid-run SHALL discard all partial scores; deassertion SHALL be synchronised to clk.

Configuration
REQ-032 Macro TMPL_ROM_OREG_EN SHALL set LAT=2, for a ROM with its output register enabled.
REQ-033 Without TMPL_ROM_OREG_EN, LAT SHALL be 1 (bypass read mode).
REQ-034 rom_oce SHALL be driven as specified in both configurations.

Structure
REQ-035 Package digit_rec_pkg SHALL hold the FSM state enum, N_TMPL, ADDR_W and SCORE_W defaults, and the LAT constant derived from the macro.
REQ-036 Sub-module tmpl_score_acc SHALL hold the valid pipe, the XNOR compare and the score counter with clear.
REQ-037 The RTL SHALL total 120-400 lines.

Verification
REQ-038 Image equal to template 3, other templates random: start -> done, best_digit=3, best_score=4096.
REQ-039 All templates identical: start -> best_digit=0, with best_score equal to the common score.
REQ-040 abort during SCAN of tmpl_sel=5 -> busy=0 next cycle, no done pulse, best_* unchanged from the prior run.
REQ-041 start held high for 3 runs -> 3 done pulses, each exactly N_TMPL*(2^ADDR_W+LAT+1)+1 cycles after its start sample; start pulses while busy are ignored.
REQ-042 rst_n low mid-DRAIN, without a clock edge -> outputs at the REQ-030 values immediately; the next run yields a correct result.
REQ-043 Run scenario REQ-038 with and without TMPL_ROM_OREG_EN, using a bench ROM model of matching latency -> best_score=4096 in both cases, with run length differing by N_TMPL cycles.

Source files
------------

// File: rtl/digit_rec_pkg.sv
// Shared types and defaults for the digit template matcher.
// Build macro TMPL_ROM_OREG_EN selects a ROM with its output register enabled (LAT=2).
package digit_rec_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SCAN,
    ST_DRAIN,
    ST_NEXT,
    ST_DONE
  } state_t;

  localparam int DEF_N_TMPL  = 10;
  localparam int DEF_ADDR_W  = 12;
  localparam int DEF_SCORE_W = DEF_ADDR_W + 1;

`ifdef TMPL_ROM_OREG_EN
  localparam int LAT = 2;
`else
  localparam int LAT = 1;
`endif

endpackage

// File: rtl/tmpl_score_acc.sv
// Per-template match counter: tracks in-flight ROM reads and counts pixels
// where the template bit equals the image bit.
module tmpl_score_acc
  import digit_rec_pkg::*;
#(
  parameter int SCORE_W = DEF_SCORE_W
)(
  input  logic               clk,
  input  logic               rst_n,
  input  logic               clr,
  input  logic               issue,
  input  logic               rom_dout,
  input  logic               img_bit,
  output logic [SCORE_W-1:0] score
);

  logic [LAT-1:0] vld;

  // clr also flushes the valid pipe so reads left over from an aborted run never count
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld   <= '0;
      score <= '0;
    end else if (clr) begin
      vld   <= '0;
      score <= '0;
    end else begin
      vld <= LAT'({vld, issue});
      if (vld[LAT-1] && (rom_dout ~^ img_bit))
        score <= score + SCORE_W'(1);
    end
  end

endmodule

// File: rtl/tmpl_match_ctrl.sv
// Scans N_TMPL template ROMs against the image buffer and reports the best-matching digit.
// ROM read latency comes from digit_rec_pkg::LAT (macro TMPL_ROM_OREG_EN).
//
// state    | meaning
// IDLE     | waiting for start; accumulators held clear
// SCAN     | issuing pixel addresses 0..2^ADDR_W-1 for tmpl_sel
// DRAIN    | LAT cycles letting the last reads return
// NEXT     | fold template score into run best, advance template
// DONE     | publish run best; done pulses on the following cycle
module tmpl_match_ctrl
  import digit_rec_pkg::*;
#(
  parameter int N_TMPL  = DEF_N_TMPL,
  parameter int ADDR_W  = DEF_ADDR_W,
  parameter int SCORE_W = ADDR_W + 1
)(
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       start,
  input  logic                       abort,
  output logic                       busy,
  output logic                       done,
  output logic [ADDR_W-1:0]          rom_ad,
  output logic                       rom_ce,
  output logic                       rom_oce,
  output logic                       rom_reset,
  output logic [$clog2(N_TMPL)-1:0]  tmpl_sel,
  input  logic                       rom_dout,
  input  logic                       img_bit,
  output logic [$clog2(N_TMPL)-1:0]  best_digit,
  output logic [SCORE_W-1:0]         best_score
);

  localparam int                SEL_W    = $clog2(N_TMPL);
  localparam logic [SEL_W-1:0]  SEL_LAST = SEL_W'(N_TMPL - 1);
  localparam logic [ADDR_W-1:0] AD_LAST  = '1;

  state_t             state;
  logic [1:0]         rst_sync;
  logic               rst_int_n;
  logic [1:0]         drain_cnt;
  logic [SEL_W-1:0]   run_digit;
  logic [SCORE_W-1:0] run_score;
  logic [SCORE_W-1:0] score;
  logic               acc_clr;
  logic               acc_issue;

  // assert immediately, release two clocks after rst_n rises
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) rst_sync <= 2'b00;
    else        rst_sync <= {rst_sync[0], 1'b1};
  end
  assign rst_int_n = rst_sync[1];

  assign rom_reset = 1'b0;
  assign acc_clr   = (state == ST_IDLE) || (state == ST_NEXT);
  assign acc_issue = (state == ST_SCAN);

  tmpl_score_acc #(.SCORE_W(SCORE_W)) u_acc (
    .clk      (clk),
    .rst_n    (rst_int_n),
    .clr      (acc_clr),
    .issue    (acc_issue),
    .rom_dout (rom_dout),
    .img_bit  (img_bit),
    .score    (score)
  );

  always_ff @(posedge clk or negedge rst_int_n) begin
    if (!rst_int_n) begin
      state      <= ST_IDLE;
      busy       <= 1'b0;
      done       <= 1'b0;
      rom_ce     <= 1'b0;
      rom_oce    <= 1'b0;
      rom_ad     <= '0;
      tmpl_sel   <= '0;
      drain_cnt  <= '0;
      run_digit  <= '0;
      run_score  <= '0;
      best_digit <= '0;
      best_score <= '0;
    end else begin
      done <= 1'b0;
      if (abort && state != ST_IDLE) begin
        state   <= ST_IDLE;
        busy    <= 1'b0;
        rom_ce  <= 1'b0;
        rom_oce <= 1'b0;
      end else begin
        case (state)
          ST_IDLE: begin
            if (start && !abort) begin
              state     <= ST_SCAN;
              busy      <= 1'b1;
              rom_ce    <= 1'b1;
              rom_oce   <= 1'b1;
              rom_ad    <= '0;
              tmpl_sel  <= '0;
              run_digit <= '0;
              run_score <= '0;
            end
          end
          ST_SCAN: begin
            if (rom_ad == AD_LAST) begin
              state     <= ST_DRAIN;
              drain_cnt <= 2'(LAT - 1);
            end else begin
              rom_ad <= rom_ad + ADDR_W'(1);
            end
          end
          ST_DRAIN: begin
            if (drain_cnt == 2'd0) begin
              state   <= ST_NEXT;
              rom_ce  <= 1'b0;
              rom_oce <= 1'b0;
            end else begin
              drain_cnt <= drain_cnt - 2'd1;
            end
          end
          ST_NEXT: begin
            // strict compare keeps the lower digit on a tie
            if (score > run_score || tmpl_sel == '0) begin
              run_score <= score;
              run_digit <= tmpl_sel;
            end
            if (tmpl_sel == SEL_LAST) begin
              state <= ST_DONE;
            end else begin
              state    <= ST_SCAN;
              tmpl_sel <= tmpl_sel + SEL_W'(1);
              rom_ad   <= '0;
              rom_ce   <= 1'b1;
              rom_oce  <= 1'b1;
            end
          end
          ST_DONE: begin
            state      <= ST_IDLE;
            busy       <= 1'b0;
            done       <= 1'b1;
            best_digit <= run_digit;
            best_score <= run_score;
          end
          default: state <= ST_IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_tmpl_match_ctrl.sv
// Randomized scoreboard bench for tmpl_match_ctrl with a behavioural ROM/image model.
module tb_tmpl_match_ctrl;

  localparam int N_TMPL  = 10;
  localparam int ADDR_W  = 6;
  localparam int SCORE_W = ADDR_W + 1;
  localparam int NPIX    = 1 << ADDR_W;
  localparam int SEL_W   = $clog2(N_TMPL);
`ifdef TMPL_ROM_OREG_EN
  localparam int TB_LAT = 2;
`else
  localparam int TB_LAT = 1;
`endif
  localparam int PER     = NPIX + TB_LAT + 1;
  localparam int RUN_LEN = N_TMPL * PER + 1;

  logic               clk = 1'b0;
  logic               rst_n = 1'b1;
  logic               start = 1'b0;
  logic               abort = 1'b0;
  logic               busy, done, rom_ce, rom_oce, rom_reset;
  logic [ADDR_W-1:0]  rom_ad;
  logic [SEL_W-1:0]   tmpl_sel, best_digit;
  logic [SCORE_W-1:0] best_score;
  logic               rom_dout, img_bit;

  tmpl_match_ctrl #(.N_TMPL(N_TMPL), .ADDR_W(ADDR_W), .SCORE_W(SCORE_W)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .start      (start),
    .abort      (abort),
    .busy       (busy),
    .done       (done),
    .rom_ad     (rom_ad),
    .rom_ce     (rom_ce),
    .rom_oce    (rom_oce),
    .rom_reset  (rom_reset),
    .tmpl_sel   (tmpl_sel),
    .rom_dout   (rom_dout),
    .img_bit    (img_bit),
    .best_digit (best_digit),
    .best_score (best_score)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // ROM + image buffer model with the configured read latency
  bit tmpl_mem [N_TMPL][NPIX];
  bit img_mem  [NPIX];
  logic [ADDR_W-1:0] a1 = '0, a2 = '0;
  always @(posedge clk) begin
    if (rom_ce)  a1 <= rom_ad;
    if (rom_oce) a2 <= a1;
  end
  always_comb begin
    logic [ADDR_W-1:0] ra;
`ifdef TMPL_ROM_OREG_EN
    ra = a2;
`else
    ra = a1;
`endif
    rom_dout = 1'b0;
    if (int'(tmpl_sel) < N_TMPL) rom_dout = tmpl_mem[tmpl_sel][ra];
    img_bit = img_mem[ra];
  end

  typedef struct { int d; int s; int c; } exp_t;
  exp_t exp_q[$];
  int n_chk = 0, n_pass = 0, done_cnt = 0;
  int last_d = 0, last_s = 0;

  task automatic check(input string name, input int act, input int req);
    n_chk++;
    if (act == req) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, req, cyc);
  endtask

  task automatic flag(input string name);
    n_chk++;
    $display("FAIL %s (cycle %0d)", name, cyc);
  endtask

  always @(negedge clk) begin
    if (rst_n && done) begin
      done_cnt++;
      if (exp_q.size() == 0) flag("unexpected_done");
      else begin
        exp_t e;
        e = exp_q.pop_front();
        check("best_digit", int'(best_digit), e.d);
        check("best_score", int'(best_score), e.s);
        check("done_cycle", cyc, e.c);
      end
    end
  end

  // expected result straight from the matching rule
  task automatic ref_best(output int d, output int s);
    d = 0; s = -1;
    for (int t = 0; t < N_TMPL; t++) begin
      int cnt = 0;
      for (int p = 0; p < NPIX; p++) if (tmpl_mem[t][p] == img_mem[p]) cnt++;
      if (cnt > s) begin s = cnt; d = t; end
    end
  endtask

  task automatic fill_random();
    for (int p = 0; p < NPIX; p++) begin
      img_mem[p] = 1'($urandom_range(0, 1));
      for (int t = 0; t < N_TMPL; t++) tmpl_mem[t][p] = 1'($urandom_range(0, 1));
    end
  endtask

  task automatic start_run(output int sc);
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0;
    sc = cyc;
    check("busy_after_start", int'(busy), 1);
  endtask

  task automatic wait_drain(input int budget);
    for (int i = 0; i < budget && exp_q.size() != 0; i++) @(negedge clk);
    if (exp_q.size() != 0) begin
      flag("timeout_waiting_done");
      exp_q.delete();
    end
  endtask

  task automatic run_and_check(input bit poke_start);
    int d, s, sc;
    ref_best(d, s);
    start_run(sc);
    exp_q.push_back('{d, s, sc + RUN_LEN});
    if (poke_start) begin
      repeat (100) @(negedge clk);
      start = 1'b1;
      @(negedge clk); start = 1'b0;
      repeat (PER) @(negedge clk);
      start = 1'b1;
      @(negedge clk); start = 1'b0;
    end
    wait_drain(RUN_LEN + 20);
    last_d = d; last_s = s;
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_busy"},       int'(busy), 0);
    check({tag, "_done"},       int'(done), 0);
    check({tag, "_rom_ce"},     int'(rom_ce), 0);
    check({tag, "_rom_oce"},    int'(rom_oce), 0);
    check({tag, "_rom_ad"},     int'(rom_ad), 0);
    check({tag, "_tmpl_sel"},   int'(tmpl_sel), 0);
    check({tag, "_best_digit"}, int'(best_digit), 0);
    check({tag, "_best_score"}, int'(best_score), 0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog expired (cycle %0d)", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    int i, d, s, sc, dc, base;

    #2 rst_n = 1'b0;
    #1 check_reset_outputs("reset");
    check("rom_reset", int'(rom_reset), 0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (4) @(negedge clk);

    // image equal to template 3
    fill_random();
    for (int p = 0; p < NPIX; p++) img_mem[p] = tmpl_mem[3][p];
    run_and_check(1'b0);
    check("idle_rom_ce", int'(rom_ce), 0);
    check("idle_rom_oce", int'(rom_oce), 0);

    // all templates identical: tie goes to digit 0
    fill_random();
    for (int p = 0; p < NPIX; p++)
      for (int t = 1; t < N_TMPL; t++) tmpl_mem[t][p] = tmpl_mem[0][p];
    run_and_check(1'b0);

    // random content, with start pulses while busy
    fill_random();
    run_and_check(1'b1);
    fill_random();
    run_and_check(1'b0);

    // abort during SCAN of template 5
    fill_random();
    start_run(sc);
    i = 0;
    while (tmpl_sel != SEL_W'(5) && i < RUN_LEN) begin @(negedge clk); i++; end
    check("reached_tmpl5", int'(tmpl_sel), 5);
    repeat (10) @(negedge clk);
    abort = 1'b1;
    @(negedge clk); abort = 1'b0;
    check("abort_busy", int'(busy), 0);
    check("abort_rom_ce", int'(rom_ce), 0);
    dc = done_cnt;
    repeat (RUN_LEN) @(negedge clk);
    check("abort_no_done", done_cnt, dc);
    check("abort_keep_digit", int'(best_digit), last_d);
    check("abort_keep_score", int'(best_score), last_s);

    // abort wins over start in IDLE
    @(negedge clk); start = 1'b1; abort = 1'b1;
    @(negedge clk); start = 1'b0; abort = 1'b0;
    check("abort_beats_start", int'(busy), 0);

    // start held high: three back-to-back runs
    fill_random();
    ref_best(d, s);
    base = done_cnt;
    @(negedge clk); start = 1'b1;
    @(negedge clk);
    sc = cyc;
    for (int k = 0; k < 3; k++) exp_q.push_back('{d, s, sc + RUN_LEN + k * (RUN_LEN + 1)});
    i = 0;
    while (done_cnt < base + 2 && i < 3 * RUN_LEN) begin @(negedge clk); i++; end
    @(negedge clk); start = 1'b0;
    wait_drain(RUN_LEN + 20);
    check("b2b_done_count", done_cnt - base, 3);
    last_d = d; last_s = s;

    // reset asserted mid-DRAIN with no clock edge
    fill_random();
    start_run(sc);
    i = 0;
    while (!(rom_ad == '1 && rom_ce) && i < RUN_LEN) begin @(negedge clk); i++; end
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1 check_reset_outputs("midrun_reset");
    @(negedge clk); rst_n = 1'b1;
    repeat (4) @(negedge clk);
    fill_random();
    for (int p = 0; p < NPIX; p++) img_mem[p] = tmpl_mem[7][p];
    run_and_check(1'b0);

    repeat (5) @(negedge clk);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
